// File: rtl/cpu_bus_initiator.sv
// HuC6280-style cartridge bus initiator: one read or write cycle per request.
// Optional macro CPU_BUS_SLOW_EN stretches every phase by SLOW_MUL when the latched hsm is 0.
`timescale 1ns/1ps
module cpu_bus_initiator #(
   parameter int T_SETUP  = 3,
   parameter int T_STROBE = 16,
   parameter int T_HOLD   = 5
`ifdef CPU_BUS_SLOW_EN
   ,
   parameter int SLOW_MUL = 4
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        region,
   input  logic        hsm,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [20:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [20:0] cpu_addr,
   output logic        cpu_oe_n,
   output logic        cpu_we_n,
   output logic        cpu_hsm,
   output logic [7:0]  cpu_d_out,
   output logic        cpu_d_oe,
   input  logic [7:0]  cpu_d_in,
   input  logic        cpu_irq_n,
   output logic        irq_pending
);

`ifdef CPU_BUS_SLOW_EN
   localparam int CW = 7;
   localparam logic [CW-1:0] SETUP_LAST_S  = CW'(T_SETUP * SLOW_MUL - 1);
   localparam logic [CW-1:0] STROBE_LAST_S = CW'(T_STROBE * SLOW_MUL - 1);
   localparam logic [CW-1:0] HOLD_LAST_S   = CW'(T_HOLD * SLOW_MUL - 1);
`else
   localparam int CW = 5;
`endif
   localparam logic [CW-1:0] SETUP_LAST  = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] STROBE_LAST = CW'(T_STROBE - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(T_HOLD - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] last_cnt;
   logic          last;
   logic          accept;
   logic          run_q;
   logic          we_q, region_q, hsm_q;
   logic [20:0]   addr_q;
   logic [7:0]    dout_q, cap_q, rdata_q;
   logic          irq_s1, irq_s2;

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   assign accept = req_valid && req_ready;

   always_comb begin
      last_cnt = HOLD_LAST;
      case (state_q)
         SETUP:   last_cnt = SETUP_LAST;
         STROBE:  last_cnt = STROBE_LAST;
         default: last_cnt = HOLD_LAST;
      endcase
`ifdef CPU_BUS_SLOW_EN
      if (!hsm_q) begin
         case (state_q)
            SETUP:   last_cnt = SETUP_LAST_S;
            STROBE:  last_cnt = STROBE_LAST_S;
            default: last_cnt = HOLD_LAST_S;
         endcase
      end
`endif
   end

   assign last = (cnt_q == last_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) state_d = SETUP;
         end
         SETUP: if (last) begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: if (last) begin
            state_d = HOLD;
            cnt_d   = '0;
         end
         HOLD: if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         we_q     <= 1'b0;
         region_q <= 1'b0;
         hsm_q    <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         cap_q    <= '0;
         rdata_q  <= '0;
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            we_q     <= req_we;
            region_q <= region;
            hsm_q    <= hsm;
            addr_q   <= req_addr;
            if (req_we) dout_q <= region ? rev8(req_wdata) : req_wdata;
         end
         // Bus data is sampled on the final strobe clock, then published at end of HOLD.
         if (state_q == STROBE && last && !we_q)
            cap_q <= region_q ? rev8(cpu_d_in) : cpu_d_in;
         if (rsp_valid && !we_q)
            rdata_q <= cap_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s1 <= 1'b0;
         irq_s2 <= 1'b0;
      end else begin
         irq_s1 <= ~cpu_irq_n;
         irq_s2 <= irq_s1;
      end
   end

   assign req_ready   = run_q && (state_q == IDLE);
   assign rsp_valid   = (state_q == HOLD) && last;
   assign rsp_rdata   = (rsp_valid && !we_q) ? cap_q : rdata_q;
   assign cpu_addr    = addr_q;
   assign cpu_hsm     = hsm_q;
   assign cpu_oe_n    = !((state_q == STROBE) && !we_q);
   assign cpu_we_n    = !((state_q == STROBE) && we_q);
   assign cpu_d_oe    = (state_q != IDLE) && we_q;
   assign cpu_d_out   = dout_q;
   assign irq_pending = irq_s2;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator: read/write timing, bit reversal, back-to-back,
// mid-cycle reset and IRQ synchronizer; cycle lengths follow CPU_BUS_SLOW_EN when defined.
`timescale 1ns/1ps
module tb_cpu_bus_initiator;

   localparam int TS = 3;
   localparam int TB = 16;
   localparam int TH = 5;
   localparam int SMUL = 4;

   logic        clk, rst_n, region, hsm, req_valid, req_ready, req_we;
   logic [20:0] req_addr, cpu_addr;
   logic [7:0]  req_wdata, rsp_rdata, cpu_d_out, cpu_d_in;
   logic        rsp_valid, cpu_oe_n, cpu_we_n, cpu_hsm, cpu_d_oe, cpu_irq_n, irq_pending;

   int checks = 0;
   int errors = 0;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

   cpu_bus_initiator dut (
      .clk(clk), .rst_n(rst_n), .region(region), .hsm(hsm),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .cpu_addr(cpu_addr), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
      .cpu_hsm(cpu_hsm), .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe),
      .cpu_d_in(cpu_d_in), .cpu_irq_n(cpu_irq_n), .irq_pending(irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int mul_of(input logic h);
      int m;
      m = 1;
`ifdef CPU_BUS_SLOW_EN
      if (!h) m = SMUL;
`endif
      return m;
   endfunction

   // One complete request; inputs are scrambled after accept to prove they were latched.
   task automatic run_cycle(input logic we, input logic [20:0] addr, input logic [7:0] wdata,
                            input logic reg_v, input logic hsm_v, input logic [7:0] bus,
                            input logic [7:0] exp_out, input logic [7:0] exp_rd,
                            input logic flip, input logic do_irq);
      int mul, cyc, cap_k, first_st, oe_cnt, we_cnt, doe_cnt, rsp_cnt, rsp_at;
      int both_low, ready_bad, addr_bad, hsm_bad, dout_bad;
      logic [7:0] rd_at;
      mul = mul_of(hsm_v);
      cyc = (TS + TB + TH) * mul;
      cap_k = (TS + TB) * mul - 1;
      first_st = -1; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; rsp_cnt = 0; rsp_at = -1;
      both_low = 0; ready_bad = 0; addr_bad = 0; hsm_bad = 0; dout_bad = 0; rd_at = 8'h00;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      region = reg_v; hsm = hsm_v; cpu_d_in = ~bus;
      `CHK("ready_before", req_ready, 1'b1)
      step();
      req_valid = 1'b0;
      req_addr  = 21'($urandom_range(0, 21'h1FFFFF));
      req_wdata = ~wdata;
      hsm       = ~hsm_v;
      if (flip) region = ~reg_v;
      for (int k = 0; k < cyc; k++) begin
         cpu_d_in = (k == cap_k) ? bus : ~bus;
         if (!cpu_oe_n) begin oe_cnt++; if (first_st < 0) first_st = k; end
         if (!cpu_we_n) begin we_cnt++; if (first_st < 0) first_st = k; end
         if (!cpu_oe_n && !cpu_we_n) both_low++;
         if (cpu_d_oe) doe_cnt++;
         if (req_ready) ready_bad++;
         if (cpu_addr !== addr) addr_bad++;
         if (cpu_hsm !== hsm_v) hsm_bad++;
         if (we && cpu_d_out !== exp_out) dout_bad++;
         if (rsp_valid) begin rsp_cnt++; rsp_at = k; rd_at = rsp_rdata; end
         if (do_irq) begin
            if (k == 4) cpu_irq_n = 1'b0;
            if (k == 7) `CHK("irq_mid_set", irq_pending, 1'b1)
            if (k == 8) cpu_irq_n = 1'b1;
            if (k == 11) `CHK("irq_mid_clr", irq_pending, 1'b0)
         end
         step();
      end
      `CHK("oe_len", oe_cnt, (we ? 0 : TB * mul))
      `CHK("we_len", we_cnt, (we ? TB * mul : 0))
      `CHK("strobe_start", first_st, TS * mul)
      `CHK("d_oe_len", doe_cnt, (we ? cyc : 0))
      `CHK("no_overlap", both_low, 0)
      `CHK("ready_busy", ready_bad, 0)
      `CHK("addr_held", addr_bad, 0)
      `CHK("hsm_held", hsm_bad, 0)
      `CHK("d_out", dout_bad, 0)
      `CHK("rsp_count", rsp_cnt, 1)
      `CHK("rsp_at", rsp_at, cyc - 1)
      `CHK("rsp_rdata", rd_at, exp_rd)
      `CHK("ready_after", req_ready, 1'b1)
      `CHK("rdata_hold", rsp_rdata, exp_rd)
      `CHK("addr_after", cpu_addr, addr)
   endtask

   initial begin
      int rq[$];
      int cyc0, b2b_rsp, b2b_both, diff;
      cyc0 = (TS + TB + TH) * mul_of(1'b0);
      rst_n = 1'b0; region = 1'b0; hsm = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; cpu_d_in = '0; cpu_irq_n = 1'b1;
      step(); step();
      `CHK("rst_ready", req_ready, 1'b0)
      `CHK("rst_rsp_valid", rsp_valid, 1'b0)
      `CHK("rst_rdata", rsp_rdata, 8'h00)
      `CHK("rst_addr", cpu_addr, 21'h0)
      `CHK("rst_oe_n", cpu_oe_n, 1'b1)
      `CHK("rst_we_n", cpu_we_n, 1'b1)
      `CHK("rst_d_oe", cpu_d_oe, 1'b0)
      `CHK("rst_d_out", cpu_d_out, 8'h00)
      `CHK("rst_hsm", cpu_hsm, 1'b0)
      `CHK("rst_irq", irq_pending, 1'b0)
      rst_n = 1'b1;
      step();
      `CHK("ready_release", req_ready, 1'b1)

      // IRQ synchronizer while idle
      cpu_irq_n = 1'b0;
      step();
      `CHK("irq_idle_1clk", irq_pending, 1'b0)
      step(); step();
      `CHK("irq_idle_set", irq_pending, 1'b1)
      cpu_irq_n = 1'b1;
      step(); step(); step();
      `CHK("irq_idle_clr", irq_pending, 1'b0)

      run_cycle(1'b0, 21'h1FFFF, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
      run_cycle(1'b0, 21'h1FFFF, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 8'h80, 1'b1, 1'b0);
      run_cycle(1'b1, 21'h00010, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h80, 1'b0, 1'b0);
      run_cycle(1'b1, 21'h00010, 8'h0F, 1'b1, 1'b0, 8'h00, 8'hF0, 8'h80, 1'b1, 1'b0);
      run_cycle(1'b0, 21'h0ABCD, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b1);
      run_cycle(1'b0, 21'h12345, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b1);

      // Back-to-back with req_valid held high
      req_valid = 1'b1; req_we = 1'b0; req_addr = 21'h00777; region = 1'b0; hsm = 1'b0;
      cpu_d_in = 8'h77; b2b_rsp = 0; b2b_both = 0;
      for (int i = 0; i < 2 * cyc0 + 10 && rq.size() < 2; i++) begin
         if (!cpu_oe_n && !cpu_we_n) b2b_both++;
         if (rsp_valid) b2b_rsp++;
         if (req_ready) rq.push_back(i);
         step();
      end
      req_valid = 1'b0;
      for (int k = 0; k < cyc0; k++) begin
         if (!cpu_oe_n && !cpu_we_n) b2b_both++;
         if (rsp_valid) b2b_rsp++;
         step();
      end
      diff = (rq.size() == 2) ? rq[1] - rq[0] : -1;
      `CHK("b2b_spacing", diff, cyc0 + 1)
      `CHK("b2b_rsp_count", b2b_rsp, 2)
      `CHK("b2b_no_overlap", b2b_both, 0)
      `CHK("b2b_rdata", rsp_rdata, 8'h77)
      `CHK("b2b_idle", req_ready, 1'b1)

      // Reset in the middle of a write strobe
      req_valid = 1'b1; req_we = 1'b1; req_addr = 21'h00055; req_wdata = 8'hAA;
      region = 1'b0; hsm = 1'b0;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) step();
      `CHK("mid_we_low", cpu_we_n, 1'b0)
      rst_n = 1'b0;
      #1;
      `CHK("mid_rst_we_n", cpu_we_n, 1'b1)
      `CHK("mid_rst_d_oe", cpu_d_oe, 1'b0)
      `CHK("mid_rst_rsp", rsp_valid, 1'b0)
      `CHK("mid_rst_addr", cpu_addr, 21'h0)
      `CHK("mid_rst_ready", req_ready, 1'b0)
      step(); step();
      `CHK("mid_rst_rsp2", rsp_valid, 1'b0)
      rst_n = 1'b1;
      step();
      `CHK("mid_rst_ready2", req_ready, 1'b1)
      run_cycle(1'b1, 21'h1ABCD, 8'h81, 1'b0, 1'b1, 8'h00, 8'h81, 8'h00, 1'b0, 1'b0);
      run_cycle(1'b0, 21'h00001, 8'h00, 1'b1, 1'b1, 8'h12, 8'h00, 8'h48, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
